// File: rtl/csr_wb_pkg.sv
// Shared CPU parameters used by the CSR write-back path: data width,
// trap cause encoding and the write-back FSM state type.
package cpu_parameters;

   localparam int XLEN = 32;

   // mcause value for an illegal-instruction exception
   localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      TRAP = 1'b1
   } csr_wb_state_t;

endpackage

// File: rtl/csr_wb_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
// Storage is not reset; an empty FIFO presents zeros on dout.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (count_r == {CW{1'b0}});
   assign full      = (count_r == CW'(DEPTH));
   assign push_ok_s = push && !full && !flush;
   assign pop_ok_s  = pop && !empty && !flush;
   assign count     = count_r;

   // Head entry, forced to zero when nothing is buffered
   always_comb begin
      dout = {WIDTH{1'b0}};
      if (!empty) begin
         dout = mem_r[rptr_r];
      end else begin
         dout = {WIDTH{1'b0}};
      end
   end

   // Data storage write; deliberately left without reset
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wptr_r] <= din;
      end
   end

   // Pointer and occupancy tracking; flush empties the FIFO in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (flush) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         if (push_ok_s && !pop_ok_s) begin
            count_r <= count_r + CW'(1);
         end else if (pop_ok_s && !push_ok_s) begin
            count_r <= count_r - CW'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

endmodule

// File: rtl/csr_wb.sv
// CSR write-back consumer: buffers CSR results, writes them through the
// shared register-file port when the ALU leaves it free, turns faulted
// accesses into an illegal-instruction trap request, and pulses retire
// for every CSR instruction that completes without a fault.
module csr_wb
   import cpu_parameters::*;
#(
   parameter int XLEN  = cpu_parameters::XLEN,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_result_v,
   input  logic [XLEN-1:0] csr_result,
   input  logic [4:0]      csr_rd,
   input  logic            csr_exception,
   output logic            csr_ok,
   input  logic            rf_port_busy,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            retire,
   output logic            trap_req,
   output logic [XLEN-1:0] trap_cause,
   input  logic            trap_ack,
   input  logic            flush
);

   localparam int EW = XLEN + 6;
   localparam int CW = $clog2(DEPTH + 1);

   csr_wb_state_t   state_r;
   csr_wb_state_t   state_next_s;

   logic [EW-1:0]   fifo_din_s;
   logic [EW-1:0]   fifo_dout_s;
   logic [CW-1:0]   fifo_count_s;
   logic            fifo_empty_s;
   logic            fifo_full_s;
   logic            push_s;
   logic            pop_s;
   logic            clear_s;

   logic [XLEN-1:0] head_result_s;
   logic [4:0]      head_rd_s;
   logic            head_exc_s;

   assign fifo_din_s = {csr_result, csr_rd, csr_exception};
   assign {head_result_s, head_rd_s, head_exc_s} = fifo_dout_s;

   // Acceptance depends only on registered state and flush, never on valid
   assign csr_ok  = !fifo_full_s && (state_r == IDLE) && !flush;
   assign push_s  = csr_result_v && csr_ok;

   // Acknowledged trap drops the faulting entry and everything behind it
   assign clear_s = flush || ((state_r == TRAP) && trap_ack);

   assign trap_req   = (state_r == TRAP);
   assign trap_cause = (state_r == TRAP) ? XLEN'(CAUSE_ILLEGAL_INSTR) : {XLEN{1'b0}};

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear_s),
      .push  (push_s),
      .pop   (pop_s),
      .din   (fifo_din_s),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   // Head decode: write-port drive, pop/retire decision and next FSM state
   always_comb begin
      rf_we        = 1'b0;
      rf_waddr     = 5'd0;
      rf_wdata     = {XLEN{1'b0}};
      retire       = 1'b0;
      pop_s        = 1'b0;
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s && !head_exc_s) begin
               rf_waddr = head_rd_s;
               rf_wdata = head_result_s;
               if (!rf_port_busy && !flush) begin
                  pop_s  = 1'b1;
                  retire = 1'b1;
                  rf_we  = (head_rd_s != 5'd0);
               end else begin
                  pop_s  = 1'b0;
                  retire = 1'b0;
                  rf_we  = 1'b0;
               end
               state_next_s = IDLE;
            end else if (!fifo_empty_s && head_exc_s) begin
               state_next_s = TRAP;
            end else begin
               state_next_s = IDLE;
            end
         end
         TRAP: begin
            if (trap_ack) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = TRAP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      if (flush) begin
         state_next_s = IDLE;
      end else begin
         state_next_s = state_next_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

endmodule

// File: tb/tb_csr_wb.sv
// Directed self-checking bench for csr_wb (XLEN=32, DEPTH=2).
// Inputs change 2 time units after a rising edge; outputs are checked 1
// unit later, well away from the next edge.
module tb_csr_wb;

   logic        clk;
   logic        rst;
   logic        csr_result_v;
   logic [31:0] csr_result;
   logic [4:0]  csr_rd;
   logic        csr_exception;
   logic        csr_ok;
   logic        rf_port_busy;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire;
   logic        trap_req;
   logic [31:0] trap_cause;
   logic        trap_ack;
   logic        flush;

   int errors = 0;
   int checks = 0;

   csr_wb #(.XLEN(32), .DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .csr_result_v  (csr_result_v),
      .csr_result    (csr_result),
      .csr_rd        (csr_rd),
      .csr_exception (csr_exception),
      .csr_ok        (csr_ok),
      .rf_port_busy  (rf_port_busy),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .retire        (retire),
      .trap_req      (trap_req),
      .trap_cause    (trap_cause),
      .trap_ack      (trap_ack),
      .flush         (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic exc);
      csr_result_v  = v;
      csr_result    = res;
      csr_rd        = rd;
      csr_exception = exc;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_we"},     64'(rf_we),      64'd0);
      check_eq({tag, "_retire"}, 64'(retire),     64'd0);
      check_eq({tag, "_treq"},   64'(trap_req),   64'd0);
      check_eq({tag, "_cause"},  64'(trap_cause), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      rf_port_busy = 1'b0;
      trap_ack = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b0);

      // ---- reset state ----
      tick();
      tick();
      #1;
      check_idle_outputs("rst");
      check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
      check_eq("rst_wdata", 64'(rf_wdata), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_ok", 64'(csr_ok), 64'd1);
      check_eq("rst_count", 64'(dut.fifo_count_s), 64'd0);

      // ---- single result ----
      tick();
      drive(1'b1, 32'hDEADBEEF, 5'd5, 1'b0);
      #1;
      check_eq("s1_ok", 64'(csr_ok), 64'd1);
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      #1;
      check_eq("s1_we",     64'(rf_we),    64'd1);
      check_eq("s1_waddr",  64'(rf_waddr), 64'd5);
      check_eq("s1_wdata",  64'(rf_wdata), 64'hDEADBEEF);
      check_eq("s1_retire", 64'(retire),   64'd1);
      tick();
      #1;
      check_eq("s1_count", 64'(dut.fifo_count_s), 64'd0);
      check_idle_outputs("s1_after");

      // ---- x0 destination ----
      drive(1'b1, 32'h1234, 5'd0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      #1;
      check_eq("x0_we",     64'(rf_we),    64'd0);
      check_eq("x0_retire", 64'(retire),   64'd1);
      check_eq("x0_wdata",  64'(rf_wdata), 64'h1234);
      tick();
      #1;
      check_eq("x0_count", 64'(dut.fifo_count_s), 64'd0);

      // ---- back-pressure ----
      rf_port_busy = 1'b1;
      drive(1'b1, 32'hAAAA_0001, 5'd1, 1'b0);
      tick();
      drive(1'b1, 32'hBBBB_0002, 5'd2, 1'b0);
      #1;
      check_eq("bp_okB",    64'(csr_ok),   64'd1);
      check_eq("bp_hold_we", 64'(rf_we),   64'd0);
      check_eq("bp_hold_rt", 64'(retire),  64'd0);
      check_eq("bp_hold_addr", 64'(rf_waddr), 64'd1);
      tick();
      drive(1'b1, 32'hCCCC_0003, 5'd3, 1'b0);
      #1;
      check_eq("bp_okC0", 64'(csr_ok), 64'd0);
      check_eq("bp_count", 64'(dut.fifo_count_s), 64'd2);
      tick();
      #1;
      check_eq("bp_okC1", 64'(csr_ok), 64'd0);
      rf_port_busy = 1'b0;
      #1;
      check_eq("bp_A_we",    64'(rf_we),    64'd1);
      check_eq("bp_A_addr",  64'(rf_waddr), 64'd1);
      check_eq("bp_A_data",  64'(rf_wdata), 64'hAAAA_0001);
      check_eq("bp_A_ret",   64'(retire),   64'd1);
      check_eq("bp_A_ok",    64'(csr_ok),   64'd0);
      tick();
      #1;
      check_eq("bp_B_we",   64'(rf_we),    64'd1);
      check_eq("bp_B_addr", 64'(rf_waddr), 64'd2);
      check_eq("bp_B_data", 64'(rf_wdata), 64'hBBBB_0002);
      check_eq("bp_C_ok",   64'(csr_ok),   64'd1);
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      #1;
      check_eq("bp_C_we",   64'(rf_we),    64'd1);
      check_eq("bp_C_addr", 64'(rf_waddr), 64'd3);
      check_eq("bp_C_data", 64'(rf_wdata), 64'hCCCC_0003);
      tick();
      #1;
      check_eq("bp_count0", 64'(dut.fifo_count_s), 64'd0);

      // ---- fault ----
      drive(1'b1, 32'h0000_0011, 5'd6, 1'b0);
      tick();
      drive(1'b1, 32'h0000_0022, 5'd7, 1'b1);
      #1;
      check_eq("ft_A_we",   64'(rf_we),    64'd1);
      check_eq("ft_A_addr", 64'(rf_waddr), 64'd6);
      check_eq("ft_A_ret",  64'(retire),   64'd1);
      tick();
      drive(1'b1, 32'h0000_0033, 5'd8, 1'b0);
      #1;
      check_eq("ft_B_ok", 64'(csr_ok), 64'd1);
      check_idle_outputs("ft_head");
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      #1;
      check_eq("ft_treq1",  64'(trap_req),   64'd1);
      check_eq("ft_cause1", 64'(trap_cause), 64'd2);
      check_eq("ft_ok",     64'(csr_ok),     64'd0);
      check_eq("ft_we1",    64'(rf_we),      64'd0);
      check_eq("ft_ret1",   64'(retire),     64'd0);
      check_eq("ft_count2", 64'(dut.fifo_count_s), 64'd2);
      tick();
      #1;
      check_eq("ft_treq2", 64'(trap_req), 64'd1);
      check_eq("ft_we2",   64'(rf_we),    64'd0);
      trap_ack = 1'b1;
      #1;
      check_eq("ft_treq_ack", 64'(trap_req), 64'd1);
      check_eq("ft_ret_ack",  64'(retire),   64'd0);
      tick();
      trap_ack = 1'b0;
      #1;
      check_idle_outputs("ft_post");
      check_eq("ft_ok_post", 64'(csr_ok), 64'd1);
      check_eq("ft_count0",  64'(dut.fifo_count_s), 64'd0);
      tick();
      #1;
      check_eq("ft_B_never", 64'(rf_we),  64'd0);
      check_eq("ft_B_noret", 64'(retire), 64'd0);

      // ---- flush colliding with a pop ----
      drive(1'b1, 32'h0000_0044, 5'd9, 1'b0);
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      flush = 1'b1;
      #1;
      check_eq("fl_we",  64'(rf_we),  64'd0);
      check_eq("fl_ret", 64'(retire), 64'd0);
      check_eq("fl_ok",  64'(csr_ok), 64'd0);
      tick();
      flush = 1'b0;
      #1;
      check_eq("fl_count", 64'(dut.fifo_count_s), 64'd0);
      check_idle_outputs("fl_post");

      // ---- flush together with trap_ack ----
      drive(1'b1, 32'h0000_0055, 5'd3, 1'b1);
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      tick();
      #1;
      check_eq("ft2_treq", 64'(trap_req), 64'd1);
      flush = 1'b1;
      trap_ack = 1'b1;
      #1;
      check_eq("ft2_we",  64'(rf_we),  64'd0);
      check_eq("ft2_ret", 64'(retire), 64'd0);
      tick();
      flush = 1'b0;
      trap_ack = 1'b0;
      #1;
      check_eq("ft2_state", 64'(dut.state_r), 64'd0);
      check_eq("ft2_count", 64'(dut.fifo_count_s), 64'd0);
      check_eq("ft2_ok",    64'(csr_ok), 64'd1);
      check_idle_outputs("ft2_post");

      // ---- async reset with two entries buffered and TRAP active ----
      drive(1'b1, 32'h0000_0066, 5'd4, 1'b1);
      tick();
      drive(1'b1, 32'h0000_0077, 5'd10, 1'b0);
      tick();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      #1;
      check_eq("ar_treq_pre",  64'(trap_req), 64'd1);
      check_eq("ar_count_pre", 64'(dut.fifo_count_s), 64'd2);
      rst = 1'b1;
      #1;
      check_idle_outputs("ar");
      check_eq("ar_waddr", 64'(rf_waddr), 64'd0);
      check_eq("ar_wdata", 64'(rf_wdata), 64'd0);
      check_eq("ar_count", 64'(dut.fifo_count_s), 64'd0);
      check_eq("ar_state", 64'(dut.state_r), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("ar_ok", 64'(csr_ok), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
